// File: rtl/clock_divider_prog_if.sv
// clock_divider_prog_if: run control, ratio programming and divided-clock outputs of the divider
interface clock_divider_prog_if #(parameter int CNT_W = 16);
  logic en;
  logic load;
  logic [CNT_W-1:0] div_ratio;
  logic clk_out;
  logic tick;
  logic ratio_ack;
  logic running;
  logic [CNT_W-1:0] cur_div;
  modport master(output en, load, div_ratio, input clk_out, tick, ratio_ack, running, cur_div);
  modport slave(input en, load, div_ratio, output clk_out, tick, ratio_ack, running, cur_div);
endinterface

// File: rtl/clock_divider_prog.sv
// clock_divider_prog: glitch-free programmable clock divider, ratio and enable applied at period boundaries
module clock_divider_prog #(
  parameter int CNT_W = 16,
  parameter int DEFAULT_DIV = 4
) (
  input logic clk_in,
  input logic reset,
  clock_divider_prog_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cur_q, cur_d, pend_q, pend_d;
  logic clk_q, clk_d, tick_q, tick_d, ack_q, ack_d, pv_q, pv_d;
  logic [CNT_W:0] hi, nxt;
  logic last, bnd;
  always_comb begin
    hi = ({1'b0, cur_q} + 1'b1) >> 1;
    nxt = {1'b0, cnt_q} + 1'b1;
    last = cnt_q == cur_q - 1'b1;
    bnd = bus.en && (state_q == IDLE || last);
    state_d = state_q;
    cnt_d = cnt_q;
    clk_d = clk_q;
    tick_d = 1'b0;
    ack_d = 1'b0;
    cur_d = cur_q;
    pend_d = pend_q;
    pv_d = pv_q;
    if (bnd) begin
      state_d = RUN;
      cnt_d = '0;
      clk_d = 1'b1;
      tick_d = 1'b1;
      if (pv_q) begin
        cur_d = pend_q;
        pv_d = 1'b0;
        ack_d = 1'b1;
      end
    end else if (state_q == RUN && !last) begin
      cnt_d = nxt[CNT_W-1:0];
      clk_d = nxt < hi;
    end else begin
      state_d = IDLE;
      cnt_d = '0;
      clk_d = 1'b0;
    end
    // a load on a boundary edge is captured after the swap, so it waits for the next boundary
    if (bus.load) begin
      pend_d = (bus.div_ratio < CNT_W'(2)) ? CNT_W'(2) : bus.div_ratio;
      pv_d = 1'b1;
    end
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      clk_q <= 1'b0;
      tick_q <= 1'b0;
      ack_q <= 1'b0;
      cur_q <= CNT_W'(DEFAULT_DIV);
      pend_q <= CNT_W'(DEFAULT_DIV);
      pv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      clk_q <= clk_d;
      tick_q <= tick_d;
      ack_q <= ack_d;
      cur_q <= cur_d;
      pend_q <= pend_d;
      pv_q <= pv_d;
    end
  end
  assign bus.clk_out = clk_q;
  assign bus.tick = tick_q;
  assign bus.ratio_ack = ack_q;
  assign bus.running = state_q == RUN;
  assign bus.cur_div = cur_q;
endmodule

// File: tb/tb_clock_divider_prog.sv
// tb_clock_divider_prog: table vectors, directed corner sequences and random run against a waveform-queue model
module tb_clock_divider_prog;
  localparam int W = 16;
  localparam int DEF = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  clock_divider_prog_if #(.CNT_W(W)) bus();
  clock_divider_prog #(.CNT_W(W), .DEFAULT_DIV(DEF)) dut(.clk_in(clk), .reset(rst), .bus(bus));
  int errors = 0;
  int checks = 0;
  bit mq[$];
  int m_n = DEF, m_pend = 0, m_pv = 0, m_clk = 0, m_tick = 0, m_ack = 0, m_run = 0;
  typedef struct {
    bit r, e, l;
    int ratio;
    bit clk_o, tick, ack, run;
    int cur;
  } vec_t;
  vec_t tbl[15];
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int pack_dut();
    return int'({bus.clk_out, bus.tick, bus.ratio_ack, bus.running, bus.cur_div});
  endfunction
  // each period is laid out as a queue of its remaining clk_out levels; an empty queue means the next edge may start a period
  task automatic model(bit r, bit e, bit l, int ratio);
    m_tick = 0;
    m_ack = 0;
    if (r) begin
      mq.delete();
      m_run = 0;
      m_n = DEF;
      m_pv = 0;
      m_clk = 0;
    end else begin
      if (e && mq.size() == 0) begin
        if (m_pv != 0) begin
          m_n = m_pend;
          m_pv = 0;
          m_ack = 1;
        end
        for (int i = 1; i < m_n; i++) mq.push_back(i < (m_n + 1) / 2);
        m_clk = 1;
        m_tick = 1;
        m_run = 1;
      end else if (mq.size() > 0) m_clk = int'(mq.pop_front());
      else begin
        m_run = 0;
        m_clk = 0;
      end
      if (l) begin
        m_pend = ratio < 2 ? 2 : ratio;
        m_pv = 1;
      end
    end
  endtask
  task automatic step(bit r, bit e, bit l, int ratio, bit do_chk = 1'b1);
    @(negedge clk);
    rst = r;
    bus.en = e;
    bus.load = l;
    bus.div_ratio = W'(ratio);
    model(r, e, l, ratio);
    @(posedge clk);
    #1;
    if (do_chk) chk("model", pack_dut(), int'({m_clk[0], m_tick[0], m_ack[0], m_run[0], W'(m_n)}));
  endtask
  task automatic run_tick(int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1'b0, 1'b1, 1'b0, 0);
      seen = bus.tick;
    end
    chk("tick_wait", int'(seen), 1);
  endtask
  initial begin
    bus.en = 1'b0;
    bus.load = 1'b0;
    bus.div_ratio = '0;
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 4};
    tbl[1] = '{0, 1, 0, 0, 1, 1, 0, 1, 4};
    tbl[2] = '{0, 1, 0, 0, 1, 0, 0, 1, 4};
    tbl[3] = '{0, 1, 0, 0, 0, 0, 0, 1, 4};
    tbl[4] = '{0, 1, 0, 0, 0, 0, 0, 1, 4};
    tbl[5] = '{0, 1, 0, 0, 1, 1, 0, 1, 4};
    tbl[6] = '{0, 1, 1, 5, 1, 0, 0, 1, 4};
    tbl[7] = '{0, 1, 0, 0, 0, 0, 0, 1, 4};
    tbl[8] = '{0, 1, 0, 0, 0, 0, 0, 1, 4};
    tbl[9] = '{0, 1, 0, 0, 1, 1, 1, 1, 5};
    tbl[10] = '{0, 1, 0, 0, 1, 0, 0, 1, 5};
    tbl[11] = '{0, 1, 0, 0, 1, 0, 0, 1, 5};
    tbl[12] = '{0, 1, 0, 0, 0, 0, 0, 1, 5};
    tbl[13] = '{0, 1, 0, 0, 0, 0, 0, 1, 5};
    tbl[14] = '{0, 1, 0, 0, 1, 1, 0, 1, 5};
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].ratio, 1'b0);
      chk($sformatf("vec%0d", i), pack_dut(),
          int'({tbl[i].clk_o, tbl[i].tick, tbl[i].ack, tbl[i].run, W'(tbl[i].cur)}));
    end
    step(0, 1, 1, 0);
    run_tick(10);
    chk("clamp0_cur", int'(bus.cur_div), 2);
    step(0, 1, 1, 1);
    run_tick(4);
    chk("clamp1_cur", int'(bus.cur_div), 2);
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0, 0);
      chk("toggle", int'(bus.clk_out), int'(i % 2 == 0));
    end
    step(0, 1, 1, 6);
    run_tick(4);
    chk("n6_cur", int'(bus.cur_div), 6);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      chk("drain_clk", int'(bus.clk_out), int'(i < 2));
      chk("drain_run", int'(bus.running), 1);
    end
    step(0, 0, 0, 0);
    chk("idle_run", int'(bus.running), 0);
    chk("idle_clk", int'(bus.clk_out), 0);
    step(0, 1, 0, 0);
    chk("restart", int'({bus.clk_out, bus.tick}), 3);
    step(0, 1, 1, 9);
    step(1, 1, 0, 0);
    chk("rst_mid", int'({bus.clk_out, bus.ratio_ack, bus.running, bus.cur_div}), int'({3'b000, W'(4)}));
    step(0, 1, 0, 0);
    chk("rst_release", int'({bus.tick, bus.ratio_ack, bus.cur_div}), int'({2'b10, W'(4)}));
    run_tick(6);
    chk("rst_no_ack", int'({bus.ratio_ack, bus.cur_div}), int'({1'b0, W'(4)}));
    step(0, 1, 1, 6);
    step(0, 1, 1, 3);
    run_tick(6);
    chk("last_load_wins", int'({bus.ratio_ack, bus.cur_div}), int'({1'b1, W'(3)}));
    run_tick(6);
    chk("single_ack", int'({bus.ratio_ack, bus.cur_div}), int'({1'b0, W'(3)}));
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 7);
    chk("bnd_load", int'({bus.tick, bus.ratio_ack, bus.cur_div}), int'({2'b10, W'(3)}));
    run_tick(6);
    chk("bnd_load_next", int'({bus.ratio_ack, bus.cur_div}), int'({1'b1, W'(7)}));
    for (int i = 0; i < 3000; i++) begin
      automatic bit r = ($urandom % 300) == 0;
      automatic bit e = ($urandom % 10) != 0;
      automatic bit l = ($urandom % 8) == 0;
      automatic int ratio = ($urandom % 6 == 0) ? int'($urandom % 2) : int'($urandom_range(2, 20));
      step(r, e, l, ratio);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
